// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for loader (LD), datapath (DT) and fetch (IF) requesters.
// Optional grant counters are enabled with the ARB_STATS_EN macro.
module mem_port_arbiter #(
    parameter int DW      = 16,
    parameter int AW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          ld_req,
    input  logic          dt_req,
    input  logic          if_req,
    input  logic          ld_we,
    input  logic          dt_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [AW-1:0] dt_addr,
    input  logic [AW-1:0] if_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic [DW-1:0] dt_wdata,
    output logic          ld_ack,
    output logic          dt_ack,
    output logic          if_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [15:0]   ld_grants,
    output logic [15:0]   dt_grants,
    output logic [15:0]   if_grants
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic [1:0] {GNT_LD, GNT_DT, GNT_IF} gnt_t;

    localparam logic [2:0] WAIT_INIT = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

    state_t        state;
    gnt_t          gid;
    gnt_t          win;
    logic          we_q;
    logic          rr_dt;
    logic [2:0]    cnt;
    logic          grant;
    logic          finish;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    assign grant  = (state == IDLE) && (ld_req || dt_req || if_req);
    assign finish = ((state == ACCESS) && (MEM_LAT == 1)) ||
                    ((state == WAIT) && (cnt == 3'd0));

    // LD has strict priority; rr_dt breaks DT/IF ties
    always_comb begin
        win       = GNT_IF;
        win_we    = 1'b0;
        win_addr  = if_addr;
        win_wdata = '0;
        if (ld_req) begin
            win       = GNT_LD;
            win_we    = ld_we;
            win_addr  = ld_addr;
            win_wdata = ld_wdata;
        end else if (dt_req && (!if_req || rr_dt)) begin
            win       = GNT_DT;
            win_we    = dt_we;
            win_addr  = dt_addr;
            win_wdata = dt_wdata;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            gid       <= GNT_LD;
            we_q      <= 1'b0;
            rr_dt     <= 1'b1;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            ld_ack    <= 1'b0;
            dt_ack    <= 1'b0;
            if_ack    <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            ld_ack <= 1'b0;
            dt_ack <= 1'b0;
            if_ack <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    state     <= ACCESS;
                    gid       <= win;
                    we_q      <= win_we;
                    mem_en    <= 1'b1;
                    mem_we    <= win_we;
                    mem_addr  <= win_addr;
                    mem_wdata <= win_wdata;
                    busy      <= 1'b1;
                    if (win == GNT_DT) rr_dt <= 1'b0;
                    else if (win == GNT_IF) rr_dt <= 1'b1;
                end
                ACCESS: begin
                    cnt   <= WAIT_INIT;
                    state <= WAIT;
                end
                WAIT: if (cnt != 3'd0) cnt <= cnt - 3'd1;
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // With MEM_LAT=1 the capture edge is the ACCESS edge itself, so WAIT is skipped
            if (finish) begin
                state  <= DONE;
                ld_ack <= (gid == GNT_LD);
                dt_ack <= (gid == GNT_DT);
                if_ack <= (gid == GNT_IF);
                if (!we_q) rdata <= mem_rdata;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] ld_cnt, dt_cnt, if_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ld_cnt <= '0;
            dt_cnt <= '0;
            if_cnt <= '0;
        end else if (grant) begin
            case (win)
                GNT_LD:  if (ld_cnt != '1) ld_cnt <= ld_cnt + 16'd1;
                GNT_DT:  if (dt_cnt != '1) dt_cnt <= dt_cnt + 16'd1;
                default: if (if_cnt != '1) if_cnt <= if_cnt + 16'd1;
            endcase
        end
    end

    assign ld_grants = ld_cnt;
    assign dt_grants = dt_cnt;
    assign if_grants = if_cnt;
`else
    assign ld_grants = '0;
    assign dt_grants = '0;
    assign if_grants = '0;
`endif

endmodule
